// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: H-bands, V-bars, checkerboard or grey ramp from raster coordinates.
// Latency 1 clk_25m (registered pixel); no backpressure, one pixel accepted every clock.
module vga_pattern_gen #(
    parameter int H_DISP      = 640,
    parameter int V_DISP      = 480,
    parameter int NUM_BARS    = 8,
    parameter int COLOR_W     = 8,
    parameter int AUTO_FRAMES = 60
) (
    input  logic                   clk_25m,
    input  logic                   rst_n,
    input  logic [10:0]            vga_xpos,
    input  logic [10:0]            vga_ypos,
    input  logic [1:0]             mode_sel,
    input  logic                   auto_en,
    output logic [3*COLOR_W-1:0]   vga_data,
    output logic [1:0]             cur_mode,
    output logic                   frame_tick
);

    localparam int BW    = H_DISP / NUM_BARS;
    localparam int BH    = V_DISP / NUM_BARS;
    localparam int CNT_W = 10;

    logic [CNT_W-1:0]       frame_cnt;
    logic                   origin_q;
    logic                   at_origin;
    logic                   boundary;
    logic [1:0]             mode_nxt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [10:0]            cx_raw;
    logic [10:0]            ry_raw;
    logic [2:0]             col_idx;
    logic [2:0]             row_idx;
    logic [21:0]            ramp_prod;
    logic [COLOR_W-1:0]     ramp_val;
    logic [3*COLOR_W-1:0]   pix_nxt;

    // Palette entry as {R,G,B} on/off flags.
    function automatic logic [2:0] pal(input logic [2:0] p);
        case (p)
            3'd0:    pal = 3'b100;
            3'd1:    pal = 3'b010;
            3'd2:    pal = 3'b001;
            3'd3:    pal = 3'b111;
            3'd4:    pal = 3'b000;
            3'd5:    pal = 3'b110;
            3'd6:    pal = 3'b101;
            default: pal = 3'b011;
        endcase
    endfunction

    function automatic logic [3*COLOR_W-1:0] expand(input logic [2:0] c);
        expand = {{COLOR_W{c[2]}}, {COLOR_W{c[1]}}, {COLOR_W{c[0]}}};
    endfunction

    // Mode/counter update; the counter idles at zero outside auto mode so cycling restarts cleanly.
    always_comb begin
        at_origin = (vga_xpos == 11'd0) && (vga_ypos == 11'd0);
        boundary  = at_origin && !origin_q;
        mode_nxt  = cur_mode;
        cnt_nxt   = frame_cnt;
        if (boundary) begin
            if (!auto_en) begin
                mode_nxt = mode_sel;
                cnt_nxt  = '0;
            end else if (frame_cnt == CNT_W'(AUTO_FRAMES - 1)) begin
                mode_nxt = cur_mode + 2'd1;
                cnt_nxt  = '0;
            end else begin
                cnt_nxt  = frame_cnt + 10'd1;
            end
        end else if (!auto_en) begin
            cnt_nxt = '0;
        end
    end

    always_comb begin
        cx_raw    = vga_xpos / 11'(BW);
        ry_raw    = vga_ypos / 11'(BH);
        col_idx   = (cx_raw > 11'(NUM_BARS - 1)) ? 3'(NUM_BARS - 1) : cx_raw[2:0];
        row_idx   = (ry_raw > 11'(NUM_BARS - 1)) ? 3'(NUM_BARS - 1) : ry_raw[2:0];
        ramp_prod = 22'(vga_xpos) * 22'((2 ** COLOR_W) - 1);
        ramp_val  = COLOR_W'(ramp_prod / 22'(H_DISP - 1));
        pix_nxt   = '0;
        case (mode_nxt)
            2'd0:    pix_nxt = expand(pal(row_idx));
            2'd1:    pix_nxt = expand(pal(col_idx));
            2'd2:    pix_nxt = (col_idx[0] ^ row_idx[0]) ? '0 : '1;
            default: pix_nxt = {3{ramp_val}};
        endcase
        if (vga_xpos >= 11'(H_DISP) || vga_ypos >= 11'(V_DISP))
            pix_nxt = '0;
    end

    always_ff @(posedge clk_25m) begin
        if (!rst_n) begin
            vga_data   <= '0;
            cur_mode   <= 2'd0;
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
            origin_q   <= 1'b0;
        end else begin
            vga_data   <= pix_nxt;
            cur_mode   <= mode_nxt;
            frame_tick <= boundary;
            frame_cnt  <= cnt_nxt;
            origin_q   <= at_origin;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: two instances (8 bars and 7 bars) driven from the same raster
// and checked against a behavioural pixel/mode model.
module tb_vga_pattern_gen;

    logic        clk_25m = 1'b0;
    logic        rst_n;
    logic [10:0] vga_xpos;
    logic [10:0] vga_ypos;
    logic [1:0]  mode_sel;
    logic        auto_en;
    logic [23:0] data8, data7;
    logic [1:0]  mode8, mode7;
    logic        tick8, tick7;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_mode, m_cnt;
    bit          m_prev;
    logic [23:0] exp_d8, exp_d7;
    int          exp_mode;
    logic        exp_tick;

    always #20 clk_25m = ~clk_25m;

    vga_pattern_gen #(.H_DISP(640), .V_DISP(480), .NUM_BARS(8), .COLOR_W(8), .AUTO_FRAMES(2)) dut8 (
        .clk_25m(clk_25m), .rst_n(rst_n), .vga_xpos(vga_xpos), .vga_ypos(vga_ypos),
        .mode_sel(mode_sel), .auto_en(auto_en), .vga_data(data8), .cur_mode(mode8),
        .frame_tick(tick8));

    vga_pattern_gen #(.H_DISP(640), .V_DISP(480), .NUM_BARS(7), .COLOR_W(8), .AUTO_FRAMES(2)) dut7 (
        .clk_25m(clk_25m), .rst_n(rst_n), .vga_xpos(vga_xpos), .vga_ypos(vga_ypos),
        .mode_sel(mode_sel), .auto_en(auto_en), .vga_data(data7), .cur_mode(mode7),
        .frame_tick(tick7));

    function automatic logic [23:0] pal(input int p);
        case (p % 8)
            0: return 24'hff0000;
            1: return 24'h00ff00;
            2: return 24'h0000ff;
            3: return 24'hffffff;
            4: return 24'h000000;
            5: return 24'hffff00;
            6: return 24'hff00ff;
            default: return 24'h00ffff;
        endcase
    endfunction

    function automatic logic [23:0] pix(input int x, input int y, input int mode, input int nb);
        int cx, ry;
        logic [7:0] v;
        if (x >= 640 || y >= 480) return 24'h0;
        cx = x / (640 / nb);
        ry = y / (480 / nb);
        if (cx > nb - 1) cx = nb - 1;
        if (ry > nb - 1) ry = nb - 1;
        case (mode)
            0: return pal(ry);
            1: return pal(cx);
            2: return ((cx % 2) == (ry % 2)) ? 24'hffffff : 24'h000000;
            default: begin
                v = 8'((x * 255) / 639);
                return {v, v, v};
            end
        endcase
    endfunction

    // Present one coordinate, advance the model, and return after the edge that samples it.
    task automatic step(input int x, input int y);
        bit origin, bnd;
        vga_xpos = 11'(x);
        vga_ypos = 11'(y);
        origin = (x == 0) && (y == 0);
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0; m_prev = 0;
            exp_d8 = 24'h0; exp_d7 = 24'h0; exp_tick = 1'b0;
        end else begin
            bnd = origin && !m_prev;
            if (bnd) begin
                if (!auto_en) begin
                    m_mode = mode_sel; m_cnt = 0;
                end else if (m_cnt == 2 - 1) begin
                    m_mode = (m_mode + 1) % 4; m_cnt = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else if (!auto_en) begin
                m_cnt = 0;
            end
            m_prev   = origin;
            exp_tick = bnd;
            exp_d8   = pix(x, y, m_mode, 8);
            exp_d7   = pix(x, y, m_mode, 7);
        end
        exp_mode = m_mode;
        @(posedge clk_25m);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; auto_en = 1'b0; mode_sel = 2'd2;
        step(100, 100);
        step(0, 0);
        checks++; if (data8 !== 24'h0) begin errors++; $display("FAIL reset_data got %h want 000000", data8); end
        checks++; if (mode8 !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", mode8); end
        checks++; if (tick8 !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick8); end
    endtask

    task automatic test_hbands;
        logic [23:0] band [8] = '{24'hff0000, 24'h00ff00, 24'h0000ff, 24'hffffff,
                                  24'h000000, 24'hffff00, 24'hff00ff, 24'h00ffff};
        mode_sel = 2'd0; auto_en = 1'b0;
        rst_n = 1'b1;
        step(0, 0);
        checks++; if (tick8 !== 1'b1) begin errors++; $display("FAIL hb_tick got %b want 1", tick8); end
        checks++; if (data8 !== 24'hff0000) begin errors++; $display("FAIL hb_origin got %h want ff0000", data8); end
        for (int b = 0; b < 8; b++) begin
            for (int e = 0; e < 2; e++) begin
                step($urandom_range(0, 639), b * 60 + e * 59);
                checks++; if (data8 !== band[b]) begin errors++; $display("FAIL hb_band%0d got %h want %h", b, data8, band[b]); end
                checks++; if (data7 !== exp_d7) begin errors++; $display("FAIL hb_nb7 got %h want %h", data7, exp_d7); end
                checks++; if (tick8 !== 1'b0) begin errors++; $display("FAIL hb_notick got %b want 0", tick8); end
            end
        end
    endtask

    task automatic test_mode_switch;
        step(300, 100);
        mode_sel = 2'd1;
        step(300, 101);
        checks++; if (data8 !== 24'h00ff00) begin errors++; $display("FAIL ms_hold got %h want 00ff00", data8); end
        checks++; if (mode8 !== 2'd0) begin errors++; $display("FAIL ms_mode_hold got %0d want 0", mode8); end
        step(0, 0);
        checks++; if (mode8 !== 2'd1) begin errors++; $display("FAIL ms_mode got %0d want 1", mode8); end
        checks++; if (data8 !== 24'hff0000) begin errors++; $display("FAIL ms_origin got %h want ff0000", data8); end
        step(80, 0);
        checks++; if (data8 !== 24'h00ff00) begin errors++; $display("FAIL ms_x80 got %h want 00ff00", data8); end
        step(639, 0);
        checks++; if (data8 !== 24'h00ffff) begin errors++; $display("FAIL ms_x639 got %h want 00ffff", data8); end
    endtask

    task automatic test_ramp;
        int xs [5] = '{0, 639, 640, 10, 320};
        int ys [5] = '{1, 10, 10, 480, 5};
        logic [23:0] want [5] = '{24'h000000, 24'hffffff, 24'h000000, 24'h000000, 24'h7f7f7f};
        mode_sel = 2'd3;
        step(5, 5);
        step(0, 0);
        checks++; if (mode8 !== 2'd3) begin errors++; $display("FAIL ramp_mode got %0d want 3", mode8); end
        checks++; if (data8 !== 24'h0) begin errors++; $display("FAIL ramp_origin got %h want 000000", data8); end
        for (int i = 0; i < 5; i++) begin
            step(xs[i], ys[i]);
            checks++; if (data8 !== want[i]) begin errors++; $display("FAIL ramp_%0d got %h want %h", i, data8, want[i]); end
        end
    endtask

    task automatic test_nb7;
        mode_sel = 2'd1;
        step(5, 5);
        step(0, 0);
        step(636, 3);
        checks++; if (data7 !== 24'hff00ff) begin errors++; $display("FAIL nb7_x636 got %h want ff00ff", data7); end
        checks++; if (data8 !== 24'h00ffff) begin errors++; $display("FAIL nb8_x636 got %h want 00ffff", data8); end
        step(639, 3);
        checks++; if (data7 !== 24'hff00ff) begin errors++; $display("FAIL nb7_x639 got %h want ff00ff", data7); end
        mode_sel = 2'd2;
        step(5, 5);
        step(0, 0);
        step(91, 0);
        checks++; if (data7 !== 24'h000000) begin errors++; $display("FAIL nb7_chk91 got %h want 000000", data7); end
        step(90, 0);
        checks++; if (data7 !== 24'hffffff) begin errors++; $display("FAIL nb7_chk90 got %h want ffffff", data7); end
        checks++; if (data8 !== 24'h000000) begin errors++; $display("FAIL nb8_chk90 got %h want 000000", data8); end
    endtask

    task automatic test_auto;
        int seq [4] = '{0, 1, 1, 2};
        int ticks;
        rst_n = 1'b0;
        step(7, 7);
        rst_n = 1'b1; auto_en = 1'b1; mode_sel = 2'd3;
        ticks = 0;
        for (int b = 0; b < 4; b++) begin
            for (int h = 0; h < ((b == 0) ? 5 : 1); h++) begin
                step(0, 0);
                if (tick8 === 1'b1) ticks++;
            end
            checks++; if (mode8 !== 2'(seq[b])) begin errors++; $display("FAIL auto_b%0d got %0d want %0d", b, mode8, seq[b]); end
            if (b == 0) begin
                checks++; if (ticks != 1) begin errors++; $display("FAIL auto_held got %0d want 1", ticks); end
            end
            step(5, 5);
            if (tick8 === 1'b1) ticks++;
            step(300, 200);
            if (tick8 === 1'b1) ticks++;
        end
        checks++; if (ticks != 4) begin errors++; $display("FAIL auto_ticks got %0d want 4", ticks); end
    endtask

    task automatic test_reset_mid;
        step(0, 0);
        checks++; if (mode8 !== 2'd2) begin errors++; $display("FAIL rm_mode2 got %0d want 2", mode8); end
        step(100, 100);
        checks++; if (data8 !== 24'hffffff) begin errors++; $display("FAIL rm_pre got %h want ffffff", data8); end
        #5 rst_n = 1'b0;
        #5 rst_n = 1'b1;
        step(300, 100);
        checks++; if (mode8 !== 2'd2 || data8 !== 24'hffffff) begin errors++; $display("FAIL rm_glitch got %0d/%h want 2/ffffff", mode8, data8); end
        rst_n = 1'b0;
        step(300, 100);
        checks++; if (data8 !== 24'h0) begin errors++; $display("FAIL rm_data got %h want 000000", data8); end
        checks++; if (mode8 !== 2'd0) begin errors++; $display("FAIL rm_mode got %0d want 0", mode8); end
        rst_n = 1'b1;
        step(300, 100);
        checks++; if (data8 !== 24'h00ff00) begin errors++; $display("FAIL rm_post got %h want 00ff00", data8); end
        step(0, 0);
        checks++; if (mode8 !== 2'd0) begin errors++; $display("FAIL rm_cnt0 got %0d want 0", mode8); end
        step(1, 1);
        step(0, 0);
        checks++; if (mode8 !== 2'd1) begin errors++; $display("FAIL rm_adv got %0d want 1", mode8); end
    endtask

    task automatic test_random;
        int x, y;
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
            mode_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                x = 0; y = 0;
            end else begin
                x = $urandom_range(0, 799);
                y = $urandom_range(0, 524);
            end
            step(x, y);
            checks++; if (data8 !== exp_d8) begin errors++; $display("FAIL rnd_d8 (%0d,%0d) got %h want %h", x, y, data8, exp_d8); end
            checks++; if (data7 !== exp_d7) begin errors++; $display("FAIL rnd_d7 (%0d,%0d) got %h want %h", x, y, data7, exp_d7); end
            checks++; if (mode8 !== 2'(exp_mode) || mode7 !== 2'(exp_mode)) begin errors++; $display("FAIL rnd_mode got %0d/%0d want %0d", mode8, mode7, exp_mode); end
            checks++; if (tick8 !== exp_tick || tick7 !== exp_tick) begin errors++; $display("FAIL rnd_tick got %b/%b want %b", tick8, tick7, exp_tick); end
        end
    endtask

    initial begin
        rst_n = 1'b0; auto_en = 1'b0; mode_sel = 2'd0;
        vga_xpos = 11'd400; vga_ypos = 11'd400;
        m_mode = 0; m_cnt = 0; m_prev = 0;
        test_reset;
        test_hbands;
        test_mode_switch;
        test_ramp;
        test_nb7;
        test_auto;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
